// File: rtl/cruise_pkg.sv
// Shared types and constants for the cruise-control sequencer.
package cruise_pkg;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    STANDBY = 3'd1,
    CRUISE  = 3'd2,
    ADJ_UP  = 3'd3,
    ADJ_DN  = 3'd4
  } cruise_state_t;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_CMP = 2'b01;
  localparam logic [1:0] MODE_SUB = 2'b11;

  localparam logic [7:0] STEP = 8'd5;

  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/cruise_edge_detect.sv
// Rising-edge detector: registered history, pulse is high in the first cycle the input is high.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) prev_q <= 1'b0;
    else          prev_q <= in_i;
  end

  assign pulse_o = in_i & ~prev_q;

endmodule

// File: rtl/cruise_controller.sv
// Cruise-control sequencer: holds the set speed and drives the external speed ALU.
module cruise_controller
  import cruise_pkg::*;
#(
  parameter logic [7:0] MAX_SPEED = 8'd200,
  parameter logic [7:0] MIN_SPEED = 8'd30
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          on,
  input  logic          off,
  input  logic          set,
  input  logic          resume,
  input  logic          accel,
  input  logic          decel,
  input  logic          brake,
  input  logic [7:0]    current_speed,
  output logic [7:0]    alu_a,
  output logic [1:0]    alu_mode,
  input  logic [7:0]    alu_result,
  input  logic          alu_G,
  input  logic          alu_Eq,
  input  logic          alu_L,
  output logic [7:0]    cruise_speed,
  output logic          cruise_active,
  output logic          throttle_up,
  output logic          throttle_down,
  output cruise_state_t state_o
);

  cruise_state_t state_q;
  logic [7:0]    speed_q;
  logic [1:0]    mode_q;
  logic          up_q, dn_q;
  logic          set_e, resume_e, accel_e, decel_e;
  logic          thr_up, thr_dn, cap_ok;

  edge_detect u_set    (.clk(clk), .reset_n(reset_n), .in_i(set),    .pulse_o(set_e));
  edge_detect u_resume (.clk(clk), .reset_n(reset_n), .in_i(resume), .pulse_o(resume_e));
  edge_detect u_accel  (.clk(clk), .reset_n(reset_n), .in_i(accel),  .pulse_o(accel_e));
  edge_detect u_decel  (.clk(clk), .reset_n(reset_n), .in_i(decel),  .pulse_o(decel_e));

  // Flags are only meaningful while the ALU is in compare mode; Eq forces both low.
  assign thr_up = (mode_q == MODE_CMP) & alu_G & ~alu_Eq;
  assign thr_dn = (mode_q == MODE_CMP) & alu_L & ~alu_Eq;
  assign cap_ok = in_range(current_speed, MIN_SPEED, MAX_SPEED);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= OFF;
      speed_q <= 8'd0;
      mode_q  <= MODE_CMP;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else if (off) begin
      state_q <= OFF;
      speed_q <= 8'd0;
      mode_q  <= MODE_CMP;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      mode_q <= MODE_CMP;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      case (state_q)
        OFF: if (on) state_q <= STANDBY;
        STANDBY: begin
          if (brake) begin
            state_q <= STANDBY;
          end else if (set_e) begin
            if (cap_ok) begin
              state_q <= CRUISE;
              speed_q <= current_speed;
            end
          end else if (resume_e && speed_q != 8'd0) begin
            state_q <= CRUISE;
          end
        end
        CRUISE: begin
          if (brake) begin
            state_q <= STANDBY;
          end else if (set_e) begin
            if (cap_ok) speed_q <= current_speed;
            up_q <= thr_up;
            dn_q <= thr_dn;
          end else if (!resume_e && accel_e) begin
            state_q <= ADJ_UP;
            mode_q  <= MODE_ADD;
          end else if (!resume_e && decel_e) begin
            state_q <= ADJ_DN;
            mode_q  <= MODE_SUB;
          end else begin
            up_q <= thr_up;
            dn_q <= thr_dn;
          end
        end
        ADJ_UP: begin
          state_q <= brake ? STANDBY : CRUISE;
          if (!brake) speed_q <= (speed_q > MAX_SPEED - STEP) ? MAX_SPEED : alu_result;
        end
        ADJ_DN: begin
          state_q <= brake ? STANDBY : CRUISE;
          if (!brake) speed_q <= (speed_q < MIN_SPEED + STEP) ? MIN_SPEED : alu_result;
        end
        default: state_q <= OFF;
      endcase
    end
  end

  assign alu_a         = speed_q;
  assign cruise_speed  = speed_q;
  assign alu_mode      = mode_q;
  assign throttle_up   = up_q;
  assign throttle_down = dn_q;
  assign cruise_active = (state_q == CRUISE) || (state_q == ADJ_UP) || (state_q == ADJ_DN);
  assign state_o       = state_q;

endmodule

// File: tb/tb_cruise_controller.sv
// Directed bench for cruise_controller with a behavioural ALU and a per-cycle reference model.
module tb_cruise_controller;
  import cruise_pkg::*;

  logic clk = 1'b0;
  logic reset_n, on, off, set, resume, accel, decel, brake;
  logic [7:0] current_speed, alu_a, alu_result, cruise_speed;
  logic [1:0] alu_mode;
  logic alu_G, alu_Eq, alu_L, cruise_active, throttle_up, throttle_down;
  cruise_state_t state_o;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  cruise_controller dut (
    .clk(clk), .reset_n(reset_n), .on(on), .off(off), .set(set), .resume(resume),
    .accel(accel), .decel(decel), .brake(brake), .current_speed(current_speed),
    .alu_a(alu_a), .alu_mode(alu_mode), .alu_result(alu_result), .alu_G(alu_G),
    .alu_Eq(alu_Eq), .alu_L(alu_L), .cruise_speed(cruise_speed),
    .cruise_active(cruise_active), .throttle_up(throttle_up),
    .throttle_down(throttle_down), .state_o(state_o)
  );

  // Behavioural ALU
  always_comb begin
    alu_result = alu_a;
    if (alu_mode == 2'b00) alu_result = alu_a + 8'd5;
    else if (alu_mode == 2'b11) alu_result = alu_a - 8'd5;
    alu_G  = alu_a > current_speed;
    alu_Eq = alu_a == current_speed;
    alu_L  = alu_a < current_speed;
  end

  // Reference model: 0 off, 1 standby, 2 cruise, 3 adjusting up, 4 adjusting down
  int m_st;
  int m_spd;
  int m_mode;
  logic m_up, m_dn;
  logic p_set, p_res, p_acc, p_dec;

  always @(posedge clk) begin
    logic es, er, ea, ed, ok;
    es = set & ~p_set;
    er = resume & ~p_res;
    ea = accel & ~p_acc;
    ed = decel & ~p_dec;
    ok = (int'(current_speed) >= 30) && (int'(current_speed) <= 200);
    m_up = 1'b0;
    m_dn = 1'b0;
    m_mode = 1;
    if (!reset_n) begin
      m_st = 0; m_spd = 0;
      p_set = 0; p_res = 0; p_acc = 0; p_dec = 0;
    end else begin
      if (off) begin
        m_st = 0; m_spd = 0;
      end else begin
        case (m_st)
          0: if (on) m_st = 1;
          1: if (!brake) begin
               if (es) begin
                 if (ok) begin m_st = 2; m_spd = int'(current_speed); end
               end else if (er && m_spd != 0) m_st = 2;
             end
          2: if (brake) m_st = 1;
             else if (!es && !er && ea) begin m_st = 3; m_mode = 0; end
             else if (!es && !er && ed) begin m_st = 4; m_mode = 3; end
             else begin
               m_up = m_spd > int'(current_speed);
               m_dn = m_spd < int'(current_speed);
               if (es && ok) m_spd = int'(current_speed);
             end
          3: if (brake) m_st = 1;
             else begin m_spd = (m_spd + 5 > 200) ? 200 : m_spd + 5; m_st = 2; end
          4: if (brake) m_st = 1;
             else begin m_spd = (m_spd - 5 < 30) ? 30 : m_spd - 5; m_st = 2; end
          default: m_st = 0;
        endcase
      end
      p_set = set; p_res = resume; p_acc = accel; p_dec = decel;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: all outputs are registered, so check on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_state", int'(state_o), m_st);
      chk("model_speed", int'(cruise_speed), m_spd);
      chk("model_alu_a", int'(alu_a), m_spd);
      chk("model_mode", int'(alu_mode), m_mode);
      chk("model_thr_up", int'(throttle_up), int'(m_up));
      chk("model_thr_dn", int'(throttle_down), int'(m_dn));
      chk("model_active", int'(cruise_active), int'(m_st >= 2));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int which);
    case (which)
      0: set = 1'b1;
      1: resume = 1'b1;
      2: accel = 1'b1;
      default: decel = 1'b1;
    endcase
    tick(1);
    set = 1'b0; resume = 1'b0; accel = 1'b0; decel = 1'b0;
  endtask

  task automatic capture(input int spd);
    current_speed = 8'(spd);
    press(0);
  endtask

  initial begin
    logic [7:0] sweep [0:3];
    sweep[0] = 8'd120; sweep[1] = 8'd130; sweep[2] = 8'd125; sweep[3] = 8'd124;
    reset_n = 1'b0; on = 1'b0; off = 1'b0; set = 1'b0; resume = 1'b0;
    accel = 1'b0; decel = 1'b0; brake = 1'b0; current_speed = 8'd0;
    @(posedge clk);
    cmp_en = 1'b1;
    tick(2);
    chk("reset_state", int'(state_o), int'(OFF));
    chk("reset_mode", int'(alu_mode), 1);
    chk("reset_speed", int'(cruise_speed), 0);
    reset_n = 1'b1;

    on = 1'b1; tick(1); on = 1'b0;
    chk("on_standby", int'(state_o), int'(STANDBY));
    chk("on_active", int'(cruise_active), 0);

    capture(80);
    chk("cap_speed", int'(cruise_speed), 80);
    chk("cap_active", int'(cruise_active), 1);
    current_speed = 8'd70; tick(1);
    chk("thr_up_70", int'(throttle_up), 1);
    current_speed = 8'd80; tick(1);
    chk("thr_eq_up", int'(throttle_up), 0);
    chk("thr_eq_dn", int'(throttle_down), 0);
    current_speed = 8'd90; tick(1);
    chk("thr_dn_90", int'(throttle_down), 1);

    capture(197); tick(1);
    accel = 1'b1; tick(1);
    chk("adj_up_state", int'(state_o), int'(ADJ_UP));
    chk("adj_up_mode", int'(alu_mode), 0);
    tick(1);
    chk("clamp_max", int'(cruise_speed), 200);
    tick(3);
    chk("held_accel", int'(cruise_speed), 200);
    accel = 1'b0; tick(1);

    capture(50); press(3); tick(1);
    chk("dec_45", int'(cruise_speed), 45);
    capture(33); press(3); tick(1);
    chk("clamp_min", int'(cruise_speed), 30);

    capture(60);
    decel = 1'b1; tick(1);
    chk("adj_dn_state", int'(state_o), int'(ADJ_DN));
    decel = 1'b0; brake = 1'b1; tick(1);
    chk("brake_state", int'(state_o), int'(STANDBY));
    chk("brake_speed", int'(cruise_speed), 60);
    chk("brake_thr", int'({throttle_up, throttle_down}), 0);
    brake = 1'b0; tick(1);
    press(1);
    chk("resume_state", int'(state_o), int'(CRUISE));
    chk("resume_speed", int'(cruise_speed), 60);
    brake = 1'b1; tick(1); brake = 1'b0;
    capture(20); tick(1);
    chk("set_low_state", int'(state_o), int'(STANDBY));
    chk("set_low_speed", int'(cruise_speed), 60);

    press(1);
    capture(125);
    for (int i = 0; i < 4; i++) begin
      current_speed = sweep[i];
      tick(2);
    end

    off = 1'b1; accel = 1'b1; tick(1);
    chk("off_state", int'(state_o), int'(OFF));
    chk("off_speed", int'(cruise_speed), 0);
    off = 1'b0; accel = 1'b0; tick(1);

    on = 1'b1; tick(1); on = 1'b0;
    capture(100);
    accel = 1'b1; tick(1);
    chk("pre_rst_state", int'(state_o), int'(ADJ_UP));
    reset_n = 1'b0; accel = 1'b0; tick(1);
    chk("rst_adj_state", int'(state_o), int'(OFF));
    chk("rst_adj_speed", int'(cruise_speed), 0);
    chk("rst_adj_mode", int'(alu_mode), 1);
    reset_n = 1'b1; tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
